// File: rtl/div_pkg.sv
// Shared types and sign helpers for the signed/unsigned divider control stage.
// Helpers work on a wide word; callers sign-extend into it and size-cast the result back.
package div_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} div_state_t;

    localparam int DIV_LAT_MAX = 15;
    localparam int CALC_W      = 64;

    function automatic logic [CALC_W-1:0] abs_val(input logic [CALC_W-1:0] value,
                                                  input logic              is_signed);
        return (is_signed && value[CALC_W-1]) ? -value : value;
    endfunction

    function automatic logic [CALC_W-1:0] neg_if(input logic [CALC_W-1:0] value,
                                                 input logic              cond);
        return cond ? -value : value;
    endfunction

endpackage

// File: rtl/div_sign_ctrl.sv
// Control wrapper around an external combinational unsigned divider: takes signed or
// unsigned operands, feeds magnitudes to the divider, sign-corrects and buffers the result.
module div_sign_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIV_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dvd,
    input  logic [WIDTH-1:0] in_dvs,
    input  logic             in_signed,
    output logic [WIDTH-1:0] div_dvd,
    output logic [WIDTH-1:0] div_dvs,
    input  logic [WIDTH-1:0] div_qot,
    input  logic [WIDTH-1:0] div_rmd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_qot,
    output logic [WIDTH-1:0] out_rmd,
    output logic             out_dbz,
    output logic             out_ovf
);

    localparam int               CNT_W    = $clog2(DIV_LAT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             live_q;
    logic             sd_q, sd_d, ss_q, ss_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] qot_q, qot_d, rmd_q, rmd_d;
    logic             valid_q, valid_d, dbz_q, dbz_d, ovf_q, ovf_d;
    logic             accept, sd_in, ss_in;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;

    // live_q keeps in_ready low until the first clock edge after reset release
    assign in_ready = live_q && (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign sd_in    = in_signed & in_dvd[WIDTH-1];
    assign ss_in    = in_signed & in_dvs[WIDTH-1];
    assign dvd_mag  = WIDTH'(abs_val({{(CALC_W-WIDTH){sd_in}}, in_dvd}, in_signed));
    assign dvs_mag  = WIDTH'(abs_val({{(CALC_W-WIDTH){ss_in}}, in_dvs}, in_signed));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sd_d    = sd_q;
        ss_d    = ss_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        qot_d   = qot_q;
        rmd_d   = rmd_q;
        valid_d = valid_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_dvs == '0) begin
                        qot_d   = '1;
                        rmd_d   = in_dvd;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else if (in_signed && in_dvd == MIN_NEG && in_dvs == '1) begin
                        qot_d   = MIN_NEG;
                        rmd_d   = '0;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        dvd_d   = dvd_mag;
                        dvs_d   = dvs_mag;
                        sd_d    = sd_in;
                        ss_d    = ss_in;
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    // Quotient sign follows both operands; remainder follows the dividend
                    qot_d   = WIDTH'(neg_if({{(CALC_W-WIDTH){1'b0}}, div_qot}, sd_q ^ ss_q));
                    rmd_d   = WIDTH'(neg_if({{(CALC_W-WIDTH){1'b0}}, div_rmd}, sd_q));
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            live_q  <= 1'b0;
            sd_q    <= 1'b0;
            ss_q    <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qot_q   <= '0;
            rmd_q   <= '0;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            sd_q    <= sd_d;
            ss_q    <= ss_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            qot_q   <= qot_d;
            rmd_q   <= rmd_d;
            valid_q <= valid_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign div_dvd   = dvd_q;
    assign div_dvs   = dvs_q;
    assign out_qot   = qot_q;
    assign out_rmd   = rmd_q;
    assign out_valid = valid_q;
    assign out_dbz   = dbz_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Bench for div_sign_ctrl: two instances (DIV_LAT=1 and DIV_LAT=3), each with a behavioural
// unsigned divider attached, checked against a plain-integer signed/unsigned division model.
module tb_div_sign_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready, a_out_dbz, a_out_ovf;
    logic [7:0] a_in_dvd, a_in_dvs, a_div_dvd, a_div_dvs, a_div_qot, a_div_rmd, a_out_qot, a_out_rmd;
    logic       b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready, b_out_dbz, b_out_ovf;
    logic [7:0] b_in_dvd, b_in_dvs, b_div_dvd, b_div_dvs, b_div_qot, b_div_rmd, b_out_qot, b_out_rmd;

    // Stand-ins for the parent-level combinational unsigned dividers
    assign a_div_qot = (a_div_dvs == 8'd0) ? 8'hFF : a_div_dvd / a_div_dvs;
    assign a_div_rmd = (a_div_dvs == 8'd0) ? a_div_dvd : a_div_dvd % a_div_dvs;
    assign b_div_qot = (b_div_dvs == 8'd0) ? 8'hFF : b_div_dvd / b_div_dvs;
    assign b_div_rmd = (b_div_dvs == 8'd0) ? b_div_dvd : b_div_dvd % b_div_dvs;

    div_sign_ctrl #(.WIDTH(8), .DIV_LAT(1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_dvd(a_in_dvd), .in_dvs(a_in_dvs), .in_signed(a_in_signed),
        .div_dvd(a_div_dvd), .div_dvs(a_div_dvs), .div_qot(a_div_qot), .div_rmd(a_div_rmd),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_qot(a_out_qot), .out_rmd(a_out_rmd), .out_dbz(a_out_dbz), .out_ovf(a_out_ovf)
    );

    div_sign_ctrl #(.WIDTH(8), .DIV_LAT(3)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_dvd(b_in_dvd), .in_dvs(b_in_dvs), .in_signed(b_in_signed),
        .div_dvd(b_div_dvd), .div_dvs(b_div_dvs), .div_qot(b_div_qot), .div_rmd(b_div_rmd),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_qot(b_out_qot), .out_rmd(b_out_rmd), .out_dbz(b_out_dbz), .out_ovf(b_out_ovf)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] prev_dvd, prev_dvs;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer division truncating toward zero, remainder takes the dividend's sign
    task automatic model(input logic [7:0] dvd, input logic [7:0] dvs, input logic sgn,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic [7:0] mdvd, output logic [7:0] mdvs,
                         output logic dbz, output logic ovf, output bit special);
        int a, b;
        a = sgn ? int'($signed(dvd)) : int'(dvd);
        b = sgn ? int'($signed(dvs)) : int'(dvs);
        dbz = 1'b0; ovf = 1'b0; special = 1'b1; mdvd = 8'd0; mdvs = 8'd0;
        if (b == 0) begin
            q = 8'hFF; r = dvd; dbz = 1'b1;
        end else if (sgn && a == -128 && b == -1) begin
            q = 8'h80; r = 8'h00; ovf = 1'b1;
        end else begin
            special = 1'b0;
            q    = 8'(a / b);
            r    = 8'(a % b);
            mdvd = 8'((a < 0) ? -a : a);
            mdvs = 8'((b < 0) ? -b : b);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] dvd, input logic [7:0] dvs, input logic sgn,
                                  input string tag);
        logic [7:0] q, r, mdvd, mdvs;
        logic       dbz, ovf;
        bit         special;
        int         lat;
        model(dvd, dvs, sgn, q, r, mdvd, mdvs, dbz, ovf, special);
        @(negedge clk);
        a_in_dvd = dvd; a_in_dvs = dvs; a_in_signed = sgn; a_in_valid = 1'b1;
        check_output({tag, ".in_ready"}, a_in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 20) begin
            check_output({tag, ".busy"}, a_in_ready, 0);
            @(negedge clk);
            lat++;
        end
        check_output({tag, ".latency"}, lat, special ? 1 : 2);
        check_output({tag, ".qot"}, a_out_qot, q);
        check_output({tag, ".rmd"}, a_out_rmd, r);
        check_output({tag, ".dbz"}, a_out_dbz, dbz);
        check_output({tag, ".ovf"}, a_out_ovf, ovf);
        check_output({tag, ".div_dvd"}, a_div_dvd, special ? prev_dvd : mdvd);
        check_output({tag, ".div_dvs"}, a_div_dvs, special ? prev_dvs : mdvs);
        if (!special) begin
            prev_dvd = mdvd;
            prev_dvs = mdvs;
        end
        check_output({tag, ".done_ready"}, a_in_ready, 0);
        a_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_out_ready = 1'b0;
        check_output({tag, ".valid_clr"}, a_out_valid, 0);
        check_output({tag, ".qot_kept"}, a_out_qot, q);
    endtask

    initial begin
        logic [7:0] rd, rs;
        logic       rsg;
        int         lat;

        reset_n = 1'b0;
        a_in_valid = 1'b0; a_in_dvd = 8'd0; a_in_dvs = 8'd0; a_in_signed = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_dvd = 8'd0; b_in_dvs = 8'd0; b_in_signed = 1'b0; b_out_ready = 1'b0;
        prev_dvd = 8'd0; prev_dvs = 8'd0;
        #12;
        check_output("rst.in_ready", a_in_ready, 0);
        check_output("rst.out_valid", a_out_valid, 0);
        check_output("rst.out_qot", a_out_qot, 0);
        check_output("rst.div_dvd", a_div_dvd, 0);
        check_output("rst.b_in_ready", b_in_ready, 0);
        #6 reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("rel.in_ready", a_in_ready, 1);
        check_output("rel.b_in_ready", b_in_ready, 1);

        apply_stimulus(8'd100, 8'd7, 1'b0, "unsigned");
        apply_stimulus(8'hF9, 8'h02, 1'b1, "neg_dvd");
        apply_stimulus(8'h07, 8'hFE, 1'b1, "neg_dvs");
        apply_stimulus(8'hF3, 8'hFB, 1'b1, "neg_both");
        apply_stimulus(8'h2A, 8'h00, 1'b0, "dbz");
        apply_stimulus(8'hF0, 8'h00, 1'b1, "dbz_signed");
        apply_stimulus(8'h80, 8'hFF, 1'b1, "ovf");
        apply_stimulus(8'h80, 8'hFF, 1'b0, "ovf_unsigned");
        apply_stimulus(8'h80, 8'h03, 1'b1, "min_neg");

        for (int i = 0; i < 40; i++) begin
            rd  = 8'($urandom);
            rsg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       rs = 8'h00;
                1: begin rs = 8'hFF; if ($urandom_range(0, 1) == 1) rd = 8'h80; end
                default: rs = 8'($urandom);
            endcase
            apply_stimulus(rd, rs, rsg, $sformatf("rand%0d", i));
        end

        // Backpressure on the DIV_LAT=3 instance, with a second request waiting behind it
        @(negedge clk);
        b_in_dvd = 8'd200; b_in_dvs = 8'd9; b_in_signed = 1'b0; b_in_valid = 1'b1;
        check_output("bp.in_ready", b_in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        b_in_dvd = 8'd50; b_in_dvs = 8'd7;
        lat = 1;
        while (!b_out_valid && lat < 20) begin
            check_output("bp.wait_ready", b_in_ready, 0);
            @(negedge clk);
            lat++;
        end
        check_output("bp.latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            check_output("bp.hold_qot", b_out_qot, 22);
            check_output("bp.hold_rmd", b_out_rmd, 2);
            check_output("bp.hold_valid", b_out_valid, 1);
            check_output("bp.hold_ready", b_in_ready, 0);
            @(negedge clk);
        end
        b_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_out_ready = 1'b0;
        check_output("bp.valid_clr", b_out_valid, 0);
        check_output("bp.idle_ready", b_in_ready, 1);
        check_output("bp.qot_kept", b_out_qot, 22);
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_output("bp2.latency", lat, 4);
        check_output("bp2.qot", b_out_qot, 7);
        check_output("bp2.rmd", b_out_rmd, 1);
        check_output("bp2.dbz", b_out_dbz, 0);
        b_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_out_ready = 1'b0;

        // Reset while the DIV_LAT=1 instance sits in WAIT
        @(negedge clk);
        a_in_dvd = 8'd50; a_in_dvs = 8'd3; a_in_signed = 1'b0; a_in_valid = 1'b1;
        @(posedge clk);
        #2 a_in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check_output("midrst.in_ready", a_in_ready, 0);
        check_output("midrst.out_valid", a_out_valid, 0);
        check_output("midrst.out_qot", a_out_qot, 0);
        check_output("midrst.out_rmd", a_out_rmd, 0);
        check_output("midrst.out_dbz", a_out_dbz, 0);
        check_output("midrst.out_ovf", a_out_ovf, 0);
        check_output("midrst.div_dvd", a_div_dvd, 0);
        check_output("midrst.div_dvs", a_div_dvs, 0);
        #4 reset_n = 1'b1;
        prev_dvd = 8'd0; prev_dvs = 8'd0;
        @(negedge clk);
        check_output("postrst.in_ready", a_in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            check_output("postrst.no_stale", a_out_valid, 0);
            @(negedge clk);
        end
        apply_stimulus(8'h9C, 8'h05, 1'b1, "postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
